// File: rtl/button_conditioner_if.sv
// Event channel from the button conditioner to the consumer: a single-entry
// valid/ready register carrying a 2-bit event code.
interface button_conditioner_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready;

  // Producer side: the conditioner drives the event, the consumer drives ready.
  modport master (
    output evt_valid,
    output evt_code,
    input  evt_ready
  );

  // Consumer side.
  modport slave (
    input  evt_valid,
    input  evt_code,
    output evt_ready
  );
endinterface

// File: rtl/button_conditioner.sv
// Conditions the raw active-low push-button: 2-FF synchroniser, debounce FSM
// with press/long/release classification, and a single-entry event register
// with a sticky drop flag for events lost while the register was full.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned LONG_CYCLES     = 27_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bbutton,
  output logic                  pressed,
  button_conditioner_if.master  evt,
  output logic                  evt_drop,
  input  logic                  clr_drop
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_RELEASE = 2'b11
  } evt_e;

  // Synchroniser
  logic sync1_q;
  logic sb_q;

  // FSM state and counters
  state_e        state_q,     state_d;
  logic [DW-1:0] dcnt_q,      dcnt_d;
  logic [LW-1:0] lcnt_q,      lcnt_d;
  logic          long_done_q, long_done_d;
  logic          pressed_q,   pressed_d;

  // Event register
  logic          evt_valid_q, evt_valid_d;
  evt_e          evt_code_q,  evt_code_d;
  logic          evt_drop_q,  evt_drop_d;
  evt_e          evt_new;

  // Saturating increments and terminal-count decodes shared by the FSM processes
  logic [DW-1:0] dcnt_inc;
  logic [LW-1:0] lcnt_inc;
  logic          deb_done;
  logic          long_hit;

  assign dcnt_inc = (dcnt_q == '1) ? dcnt_q : dcnt_q + DW'(1);
  assign lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + LW'(1);
  assign deb_done = (dcnt_q == D_LAST);
  assign long_hit = !long_done_q && (lcnt_q == L_LAST);

  // Two-flop synchroniser; both stages reset to the released (high) level.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours, exactly like hardware.
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sb_q    <= 1'b1;
    end else begin
      sync1_q <= bbutton;
      sb_q    <= sync1_q;
    end
  end

  // FSM state register together with the counters and flags it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      pressed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      pressed_q   <= pressed_d;
    end
  end

  // Next-state logic: debounce both edges, time the long hold while down.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    pressed_d   = pressed_q;
    unique case (state_q)
      IDLE: begin
        if (!sb_q) begin
          state_d = PRESS_DB;
          dcnt_d  = '0;
        end
      end
      PRESS_DB: begin
        if (sb_q) begin
          state_d = IDLE;
        end else if (deb_done) begin
          state_d     = HELD;
          pressed_d   = 1'b1;
          lcnt_d      = '0;
          long_done_d = 1'b0;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      HELD: begin
        if (sb_q) begin
          state_d = REL_DB;
          dcnt_d  = '0;
        end else if (long_hit) begin
          long_done_d = 1'b1;
        end else if (!long_done_q) begin
          lcnt_d = lcnt_inc;
        end
      end
      REL_DB: begin
        // A bounce back low resumes the hold; lcnt/long_done are kept so a
        // release bounce neither restarts nor repeats the long-press timer.
        if (!sb_q) begin
          state_d = HELD;
        end else if (deb_done) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else begin
          dcnt_d = dcnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: which event, if any, the FSM emits on this edge.
  always_comb begin
    evt_new = EVT_NONE;
    unique case (state_q)
      PRESS_DB: if (!sb_q && deb_done) evt_new = EVT_PRESS;
      HELD:     if (!sb_q && long_hit) evt_new = EVT_LONG;
      REL_DB:   if (sb_q && deb_done)  evt_new = EVT_RELEASE;
      default:  evt_new = EVT_NONE;
    endcase
  end

  // Event register next state: drain on handshake, load or drop a new event.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_drop_d  = evt_drop_q;
    if (evt_valid_q && evt.evt_ready) begin
      evt_valid_d = 1'b0;
      evt_code_d  = EVT_NONE;
    end
    if (clr_drop) begin
      evt_drop_d = 1'b0;
    end
    if (evt_new != EVT_NONE) begin
      if (!evt_valid_q || evt.evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = evt_new;
      end else begin
        // Register full and not draining: keep the oldest event, flag the
        // loss. Placed after the clear so a simultaneous set wins.
        evt_drop_d = 1'b1;
      end
    end
  end

  // Event register and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid_q <= 1'b0;
      evt_code_q  <= EVT_NONE;
      evt_drop_q  <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_drop_q  <= evt_drop_d;
    end
  end

  assign pressed       = pressed_q;
  assign evt_drop      = evt_drop_q;
  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_code  = evt_code_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small debounce/long constants.
// Expected events (code plus the cycle they must appear) are queued when the
// stimulus is driven and popped by a monitor when the DUT presents them.
`timescale 1ns/100ps

module tb_button_conditioner;

  localparam int D   = 8;
  localparam int L   = 40;
  localparam int LAT = D + 3;   // edges from first low/high sample to event

  localparam logic [1:0] C_NONE    = 2'b00;
  localparam logic [1:0] C_PRESS   = 2'b01;
  localparam logic [1:0] C_LONG    = 2'b10;
  localparam logic [1:0] C_RELEASE = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  logic bbutton;
  logic pressed;
  logic evt_drop;
  logic clr_drop;

  button_conditioner_if evt_if ();

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bbutton  (bbutton),
    .pressed  (pressed),
    .evt      (evt_if),
    .evt_drop (evt_drop),
    .clr_drop (clr_drop)
  );

  // ~27 MHz clock
  always #18.5 clk = ~clk;

  // Free-running edge counter; stable when read at the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Bounded wait: advance falling edges until the edge counter reaches c.
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: each newly presented event is matched against the queue head.
  bit pending = 1'b0;
  exp_t e;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pending = 1'b0;
    end else if (evt_if.evt_valid && !pending) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL evt_unexpected: observed code %0d expected no event (cycle %0d)", evt_if.evt_code, cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("evt_code", 32'(evt_if.evt_code), 32'(e.code));
        check("evt_cycle", cyc, e.cyc);
      end
      pending = !evt_if.evt_ready;
    end else if (pending && (!evt_if.evt_valid || evt_if.evt_ready)) begin
      pending = 1'b0;
    end
  end

  int t0;
  int r;

  initial begin
    rst_n            = 1'b0;
    bbutton          = 1'b1;
    clr_drop         = 1'b0;
    evt_if.evt_ready = 1'b1;

    // Reset values
    #5;
    check("rst_pressed", pressed, 0);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_code", 32'(evt_if.evt_code), 32'(C_NONE));
    check("rst_drop", evt_drop, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: clean press, 30 cycles low
    t0 = cyc;
    bbutton = 1'b0;
    exp_q.push_back('{code: C_PRESS, cyc: t0 + LAT});
    wait_to(t0 + LAT - 1);
    check("t1_pressed_before", pressed, 0);
    wait_to(t0 + LAT);
    check("t1_pressed_rise", pressed, 1);
    wait_to(t0 + 30);
    bbutton = 1'b1;
    exp_q.push_back('{code: C_RELEASE, cyc: t0 + 30 + LAT});
    wait_to(t0 + 30 + LAT - 1);
    check("t1_pressed_hold", pressed, 1);
    wait_to(t0 + 30 + LAT);
    check("t1_pressed_fall", pressed, 0);
    wait_to(t0 + 60);
    check("t1_drop", evt_drop, 0);
    check("t1_drained", exp_q.size(), 0);

    // 2: press bounce low 5, high 2, then low 30; timed from the final fall
    t0 = cyc;
    bbutton = 1'b0;
    exp_q.push_back('{code: C_PRESS, cyc: t0 + 7 + LAT});
    for (int c = t0; c < t0 + 7 + LAT; c++) begin
      wait_to(c);
      if (c == t0 + 5) bbutton = 1'b1;
      if (c == t0 + 7) bbutton = 1'b0;
      check("t2_no_pulse", pressed, 0);
    end
    wait_to(t0 + 7 + LAT);
    check("t2_pressed_rise", pressed, 1);
    wait_to(t0 + 37);
    bbutton = 1'b1;
    exp_q.push_back('{code: C_RELEASE, cyc: t0 + 37 + LAT});
    wait_to(t0 + 65);
    check("t2_drained", exp_q.size(), 0);

    // 3: 7-cycle glitch is shorter than the debounce window
    t0 = cyc;
    bbutton = 1'b0;
    wait_to(t0 + 7);
    bbutton = 1'b1;
    for (int c = t0; c < t0 + 25; c++) begin
      wait_to(c);
      check("t3_pressed", pressed, 0);
    end
    check("t3_no_event", exp_q.size(), 0);

    // 4: long hold with a 3-cycle high bounce at cycle 30. The long timer
    // stalls for the three high samples plus the edge returning to HELD.
    t0 = cyc;
    bbutton = 1'b0;
    exp_q.push_back('{code: C_PRESS, cyc: t0 + LAT});
    wait_to(t0 + 30);
    bbutton = 1'b1;
    wait_to(t0 + 33);
    bbutton = 1'b0;
    exp_q.push_back('{code: C_LONG, cyc: t0 + LAT + L + 4});
    for (int c = t0 + 33; c < t0 + 42; c++) begin
      wait_to(c);
      check("t4_pressed_bounce", pressed, 1);
    end
    wait_to(t0 + 70);
    bbutton = 1'b1;
    exp_q.push_back('{code: C_RELEASE, cyc: t0 + 70 + LAT});
    wait_to(t0 + 100);
    check("t4_drop", evt_drop, 0);
    check("t4_drained", exp_q.size(), 0);

    // 5: back-pressure over a whole press/release; RELEASE is dropped
    evt_if.evt_ready = 1'b0;
    t0 = cyc;
    bbutton = 1'b0;
    exp_q.push_back('{code: C_PRESS, cyc: t0 + LAT});
    for (int c = t0 + LAT + 1; c < t0 + 46; c++) begin
      wait_to(c);
      if (c == t0 + 30) bbutton = 1'b1;
      check("t5_valid_held", evt_if.evt_valid, 1);
      check("t5_code_stable", 32'(evt_if.evt_code), 32'(C_PRESS));
      check("t5_drop", evt_drop, (c >= t0 + 30 + LAT) ? 1 : 0);
    end
    evt_if.evt_ready = 1'b1;
    wait_to(t0 + 46);
    evt_if.evt_ready = 1'b0;
    check("t5_empty_valid", evt_if.evt_valid, 0);
    check("t5_empty_code", 32'(evt_if.evt_code), 32'(C_NONE));
    check("t5_drop_sticky", evt_drop, 1);
    clr_drop = 1'b1;
    wait_to(t0 + 47);
    clr_drop = 1'b0;
    check("t5_drop_cleared", evt_drop, 0);
    check("t5_drained", exp_q.size(), 0);

    // 6: reset while HELD with the button down and a PRESS still pending
    t0 = cyc;
    bbutton = 1'b0;
    exp_q.push_back('{code: C_PRESS, cyc: t0 + LAT});
    wait_to(t0 + 20);
    check("t6_pressed_before", pressed, 1);
    check("t6_valid_before", evt_if.evt_valid, 1);
    #5;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pressed", pressed, 0);
    check("t6_rst_valid", evt_if.evt_valid, 0);
    check("t6_rst_code", 32'(evt_if.evt_code), 32'(C_NONE));
    check("t6_rst_drop", evt_drop, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    r = cyc;
    exp_q.push_back('{code: C_PRESS, cyc: r + LAT});
    wait_to(r + LAT - 1);
    check("t6_pressed_before_rearm", pressed, 0);
    wait_to(r + LAT);
    check("t6_pressed_rearm", pressed, 1);
    check("t6_drop_after", evt_drop, 0);
    wait_to(r + 20);
    bbutton = 1'b1;
    exp_q.push_back('{code: C_RELEASE, cyc: r + 20 + LAT});
    wait_to(r + 50);
    check("t6_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
